sfr_bank: RTL and testbench
===========================

# sfr_bank

Parametrised special-function register bank for the memory stage. It replaces the fixed 32 x 8 SFR file with a generalised version that has:
- configurable data width, depth, pointer count and export/import counts;
- independent per-pointer increment/decrement, so several pointers can update in the same cycle;
- per-pointer wrap flags.

Address pointers are read by the load/store unit, exported registers drive the interrupt controller and ports, and imported registers capture peripheral status every cycle.

## Interface
Parameters:
- DATA_W, 8: register width in bits.
- NUM_REGS, 32: register count. AW = $clog2(NUM_REGS).
- NUM_PTRS, 4: number of 2*DATA_W-bit pointers. Pointer k occupies address 2k (low byte) and 2k+1 (high byte).
- NUM_OUT, 4: exported registers at addresses 2*NUM_PTRS .. 2*NUM_PTRS+NUM_OUT-1.
- NUM_IN, 4: imported, read-only registers at addresses NUM_REGS-NUM_IN .. NUM_REGS-1.
- Legal configurations satisfy 2*NUM_PTRS+NUM_OUT+NUM_IN <= NUM_REGS. Remaining addresses are general-purpose.

Ports:
- clock  in  1  system clock, rising edge.
- nreset  in  1  reset, synchronous, active-low.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  read address.
- rd_data  out  DATA_W  registered read data.
- ptr_inc  in  NUM_PTRS  per-pointer post-increment request.
- ptr_dec  in  NUM_PTRS  per-pointer decrement request.
- ptr_out  out  NUM_PTRS*2*DATA_W  pointer values; pointer k at [k*2*DATA_W +: 2*DATA_W].
- ptr_wrap  out  NUM_PTRS  one-cycle pulse when pointer k wrapped.
- sfr_in  in  NUM_IN*DATA_W  peripheral inputs; slice j is captured into address NUM_REGS-NUM_IN+j.
- sfr_out  out  NUM_OUT*DATA_W  exported registers; slice j comes from address 2*NUM_PTRS+j.

## Operation
- Storage is NUM_REGS x DATA_W flops. Everything is updated on the rising clock edge.
- Reset (nreset=0): all registers, rd_data and ptr_wrap are cleared to 0, so ptr_out=0 and sfr_out=0. Reset overrides every other input.
- Write: when wr_en=1, register wr_addr takes wr_data. Writes are ignored for:
  - imported addresses;
  - addresses >= NUM_REGS.
- Pointer update for pointer k:
  - inc only: value+1.
  - dec only: value-1.
  - inc and dec together: no change, no wrap.
  - Arithmetic is modulo 2^(2*DATA_W).
  - All pointers update independently within the same cycle.
- Write/pointer collision: a write to either byte of pointer k wins. Pointer k's inc/dec is discarded that cycle and its ptr_wrap stays 0. Other pointers update normally.
- Wrap: ptr_wrap[k]=1 for exactly the cycle after:
  - an increment from all-ones to 0; or
  - a decrement from 0 to all-ones.
  - Otherwise ptr_wrap[k]=0.
- Import: every cycle, each imported register takes its sfr_in slice. Import never stalls.
- Read:
  - When rd_en=1, rd_data takes the pre-edge contents of rd_addr (read-old on same-cycle write or pointer update).
  - When rd_en=0, rd_data takes 0.
  - An address >= NUM_REGS returns 0.
- ptr_out and sfr_out are driven directly from storage (no extra register).

## Timing
- Read latency: 1 cycle. rd_data is valid the cycle after rd_en.
- Write and pointer-update latency: 1 cycle. The new value is visible on ptr_out/sfr_out the cycle after the strobe. A read issued in that later cycle returns it.
- Import latency: 1 cycle from sfr_in to storage. A read adds 1 cycle, giving 2 cycles from sfr_in to rd_data.
- Back-to-back inc on every cycle advances the pointer by 1 per cycle. There is no bubble.
- Reset asserted mid-stream: the next edge clears everything. Requests presented in the reset cycle are lost.

## Configuration
- SFR_WRITE_MASK_EN defined:
  - adds input wr_mask [DATA_W];
  - a write updates only the bits where wr_mask=1; the other bits keep their value;
  - a write with wr_mask=0 still counts as a write for pointer collision.
- Undefined: the wr_mask port is absent and writes replace the full register.

## Test plan
All scenarios use default parameters.
- Reset with all registers previously nonzero -> the cycle after the reset edge: ptr_out=0, sfr_out=0, rd_data=0, ptr_wrap=0.
- Write 0xFF to addr 0 and 0xFF to addr 1, then ptr_inc=4'b0001 for one cycle -> the cycle after the inc: ptr_out[15:0]=0x0000 and ptr_wrap=4'b0001; the following cycle ptr_wrap=0.
- ptr_inc=4'b0101 and ptr_dec=4'b0110 together for 3 cycles from all pointers = 0x0010:
  - pointer 0 = 0x0013; pointer 1 = 0x000D;
  - pointer 2 = 0x0010 (inc+dec cancel); pointer 3 = 0x0010.
- Write 0x55 to addr 2 in the same cycle as ptr_inc[1] with pointer 1 = 0x00A0 -> pointer 1 = 0x0055 and ptr_wrap[1]=0.
- sfr_in slice 0 = 0x3C, read addr 28 -> 0x3C two cycles after sfr_in is applied. Write 0x00 to addr 28 -> the next read still returns 0x3C.
- Write 0x9A to addr 8 while reading addr 8 in the same cycle -> rd_data = old value; the next read returns 0x9A and sfr_out[7:0]=0x9A.
  - With SFR_WRITE_MASK_EN and wr_mask=0x0F, writing 0xFF over 0x9A -> 0x9F.

Source files
------------

// File: rtl/sfr_bank.sv
// Parametrised SFR bank: pointer pairs, exported and imported registers, general-purpose storage.
// Optional SFR_WRITE_MASK_EN adds a per-bit write mask (wr_mask) to register writes.

module sfr_ptr_lane #(
  parameter int PW = 16
) (
  input  logic [PW-1:0] val_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [PW-1:0] nxt_o,
  output logic          wrap_o
);
  logic inc_only, dec_only;

  assign inc_only = inc_i & ~dec_i;
  assign dec_only = dec_i & ~inc_i;

  always_comb begin
    nxt_o  = val_i;
    wrap_o = 1'b0;
    if (inc_only) begin
      nxt_o  = val_i + 1'b1;
      wrap_o = &val_i;
    end else if (dec_only) begin
      nxt_o  = val_i - 1'b1;
      wrap_o = ~|val_i;
    end
  end
endmodule

module sfr_bank #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 32,
  parameter int NUM_PTRS = 4,
  parameter int NUM_OUT  = 4,
  parameter int NUM_IN   = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
`ifdef SFR_WRITE_MASK_EN
  input  logic [DATA_W-1:0]            wr_mask,
`endif
  input  logic                         rd_en,
  input  logic [AW-1:0]                rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  input  logic [NUM_PTRS-1:0]          ptr_inc,
  input  logic [NUM_PTRS-1:0]          ptr_dec,
  output logic [NUM_PTRS*2*DATA_W-1:0] ptr_out,
  output logic [NUM_PTRS-1:0]          ptr_wrap,
  input  logic [NUM_IN*DATA_W-1:0]     sfr_in,
  output logic [NUM_OUT*DATA_W-1:0]    sfr_out
);
  localparam int PW       = 2*DATA_W;
  localparam int OUT_BASE = 2*NUM_PTRS;
  localparam int IN_BASE  = NUM_REGS - NUM_IN;
  localparam logic [AW:0] IN_BASE_L = (AW+1)'(IN_BASE);
  localparam logic [AW:0] NREGS_L   = (AW+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_PTRS-1:0] wrap_q, wrap_d;

  logic [NUM_PTRS-1:0][PW-1:0] ptr_val, ptr_nxt;
  logic [NUM_PTRS-1:0]         ptr_wr, lane_wrap;
  logic [DATA_W-1:0]           wr_val;
  logic                        wr_ok;

  // Imported registers and out-of-range addresses are not writable.
  assign wr_ok = wr_en & ({1'b0, wr_addr} < IN_BASE_L);

`ifdef SFR_WRITE_MASK_EN
  assign wr_val = (regs_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
`else
  assign wr_val = wr_data;
`endif

  genvar gk, gj;
  generate
    for (gk = 0; gk < NUM_PTRS; gk++) begin : g_ptr
      assign ptr_val[gk] = {regs_q[2*gk+1], regs_q[2*gk]};
      // Any write to either byte claims the pointer, even a fully masked one.
      assign ptr_wr[gk]  = wr_en & ((wr_addr == AW'(2*gk)) | (wr_addr == AW'(2*gk+1)));
    end
    for (gj = 0; gj < NUM_OUT; gj++) begin : g_out
      assign sfr_out[gj*DATA_W +: DATA_W] = regs_q[OUT_BASE+gj];
    end
  endgenerate

  sfr_ptr_lane #(.PW(PW)) u_lane [NUM_PTRS-1:0] (
    .val_i  (ptr_val),
    .inc_i  (ptr_inc),
    .dec_i  (ptr_dec),
    .nxt_o  (ptr_nxt),
    .wrap_o (lane_wrap)
  );

  always_comb begin
    regs_d = regs_q;
    wrap_d = lane_wrap & ~ptr_wr;
    for (int k = 0; k < NUM_PTRS; k++) begin
      if (!ptr_wr[k]) begin
        regs_d[2*k]   = ptr_nxt[k][DATA_W-1:0];
        regs_d[2*k+1] = ptr_nxt[k][PW-1:DATA_W];
      end
    end
    if (wr_ok) regs_d[wr_addr] = wr_val;
    for (int j = 0; j < NUM_IN; j++) regs_d[IN_BASE+j] = sfr_in[j*DATA_W +: DATA_W];
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_en && ({1'b0, rd_addr} < NREGS_L)) rd_data_d = regs_q[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_data_q <= '0;
      wrap_q    <= '0;
    end else begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
      wrap_q    <= wrap_d;
    end
  end

  assign ptr_out  = ptr_val;
  assign ptr_wrap = wrap_q;
  assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_sfr_bank.sv
// Bench for sfr_bank: directed vector table, reset corner case, and random traffic against a byte-array model.

module tb_sfr_bank;
  logic        clock = 1'b0;
  logic        nreset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  wr_mask;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [3:0]  ptr_inc, ptr_dec;
  logic [63:0] ptr_out;
  logic [3:0]  ptr_wrap;
  logic [31:0] sfr_in;
  logic [31:0] sfr_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sfr_bank dut (
    .clock(clock), .nreset(nreset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SFR_WRITE_MASK_EN
    .wr_mask(wr_mask),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .ptr_inc(ptr_inc), .ptr_dec(ptr_dec), .ptr_out(ptr_out), .ptr_wrap(ptr_wrap),
    .sfr_in(sfr_in), .sfr_out(sfr_out)
  );

  // Reference model: a plain byte array, pointers handled as integers.
  logic [7:0] m [32];
  logic [7:0] mrd;
  logic [3:0] mwrap;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] nm [32];
    int p, np;
    bit hit, w;
    if (!nreset) begin
      for (int i = 0; i < 32; i++) m[i] = 8'h00;
      mrd = 8'h00;
      mwrap = 4'h0;
      return;
    end
    nm = m;
    mrd = rd_en ? m[rd_addr] : 8'h00;
    for (int k = 0; k < 4; k++) begin
      hit = wr_en && (int'(wr_addr) / 2 == k);
      p = int'(m[2*k]) + 256 * int'(m[2*k+1]);
      np = p;
      w = 1'b0;
      if (!hit && ptr_inc[k] && !ptr_dec[k]) begin
        np = (p + 1) % 65536; w = (p == 65535);
      end else if (!hit && ptr_dec[k] && !ptr_inc[k]) begin
        np = (p + 65535) % 65536; w = (p == 0);
      end
      nm[2*k]   = 8'(np % 256);
      nm[2*k+1] = 8'(np / 256);
      mwrap[k]  = w;
    end
    if (wr_en && wr_addr < 5'd28) begin
`ifdef SFR_WRITE_MASK_EN
      nm[wr_addr] = (m[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
`else
      nm[wr_addr] = wr_data;
`endif
    end
    for (int j = 0; j < 4; j++) nm[28+j] = sfr_in[8*j +: 8];
    m = nm;
  endtask

  function automatic logic [63:0] exp_ptr();
    logic [63:0] e;
    for (int k = 0; k < 4; k++) e[16*k +: 16] = {m[2*k+1], m[2*k]};
    return e;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("model_rd_data", {56'd0, rd_data}, {56'd0, mrd});
    chk("model_ptr_out", ptr_out, exp_ptr());
    chk("model_ptr_wrap", {60'd0, ptr_wrap}, {60'd0, mwrap});
    chk("model_sfr_out", {32'd0, sfr_out}, {32'd0, m[11], m[10], m[9], m[8]});
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_mask = 8'hFF;
    rd_en = 0; rd_addr = 0; ptr_inc = 0; ptr_dec = 0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [7:0]  wd;
    logic        re;
    logic [4:0]  ra;
    logic [3:0]  inc, dec;
    logic [31:0] sin;
    logic [63:0] eptr;
    logic [3:0]  ewrap;
    logic [7:0]  erd;
  } vec_t;

  function automatic vec_t v(logic we, logic [4:0] wa, logic [7:0] wd, logic re, logic [4:0] ra,
                             logic [3:0] inc, logic [3:0] dec, logic [31:0] sin,
                             logic [63:0] eptr, logic [3:0] ewrap, logic [7:0] erd);
    vec_t t;
    t.we = we; t.wa = wa; t.wd = wd; t.re = re; t.ra = ra; t.inc = inc; t.dec = dec;
    t.sin = sin; t.eptr = eptr; t.ewrap = ewrap; t.erd = erd;
    return t;
  endfunction

  vec_t vt [23];

  initial begin
    idle();
    sfr_in = 0;
    nreset = 0;
    tick();
    tick();
    chk("reset_ptr_out", ptr_out, 64'd0);
    chk("reset_sfr_out", {32'd0, sfr_out}, 64'd0);
    chk("reset_rd_data", {56'd0, rd_data}, 64'd0);
    nreset = 1;

    //           we wa     wd     re ra     inc   dec   sin            ptr_out                 wrap  rd
    vt[0]  = v(1, 5'd0,  8'hFF, 0, 5'd0,  4'h0, 4'h0, 32'h0,  64'h0000_0000_0000_00FF, 4'h0, 8'h00);
    vt[1]  = v(1, 5'd1,  8'hFF, 0, 5'd0,  4'h0, 4'h0, 32'h0,  64'h0000_0000_0000_FFFF, 4'h0, 8'h00);
    vt[2]  = v(0, 5'd0,  8'h00, 0, 5'd0,  4'h1, 4'h0, 32'h0,  64'h0000_0000_0000_0000, 4'h1, 8'h00);
    vt[3]  = v(0, 5'd0,  8'h00, 0, 5'd0,  4'h0, 4'h0, 32'h0,  64'h0000_0000_0000_0000, 4'h0, 8'h00);
    vt[4]  = v(1, 5'd0,  8'h10, 0, 5'd0,  4'h0, 4'h0, 32'h0,  64'h0000_0000_0000_0010, 4'h0, 8'h00);
    vt[5]  = v(1, 5'd2,  8'h10, 0, 5'd0,  4'h0, 4'h0, 32'h0,  64'h0000_0000_0010_0010, 4'h0, 8'h00);
    vt[6]  = v(1, 5'd4,  8'h10, 0, 5'd0,  4'h0, 4'h0, 32'h0,  64'h0000_0010_0010_0010, 4'h0, 8'h00);
    vt[7]  = v(1, 5'd6,  8'h10, 0, 5'd0,  4'h0, 4'h0, 32'h0,  64'h0010_0010_0010_0010, 4'h0, 8'h00);
    vt[8]  = v(0, 5'd0,  8'h00, 0, 5'd0,  4'h5, 4'h6, 32'h0,  64'h0010_0010_000F_0011, 4'h0, 8'h00);
    vt[9]  = v(0, 5'd0,  8'h00, 0, 5'd0,  4'h5, 4'h6, 32'h0,  64'h0010_0010_000E_0012, 4'h0, 8'h00);
    vt[10] = v(0, 5'd0,  8'h00, 0, 5'd0,  4'h5, 4'h6, 32'h0,  64'h0010_0010_000D_0013, 4'h0, 8'h00);
    vt[11] = v(1, 5'd2,  8'hA0, 0, 5'd0,  4'h0, 4'h0, 32'h0,  64'h0010_0010_00A0_0013, 4'h0, 8'h00);
    vt[12] = v(1, 5'd2,  8'h55, 0, 5'd0,  4'h2, 4'h0, 32'h0,  64'h0010_0010_0055_0013, 4'h0, 8'h00);
    vt[13] = v(0, 5'd0,  8'h00, 1, 5'd28, 4'h0, 4'h0, 32'h3C, 64'h0010_0010_0055_0013, 4'h0, 8'h00);
    vt[14] = v(0, 5'd0,  8'h00, 1, 5'd28, 4'h0, 4'h0, 32'h3C, 64'h0010_0010_0055_0013, 4'h0, 8'h3C);
    vt[15] = v(1, 5'd28, 8'h00, 1, 5'd28, 4'h0, 4'h0, 32'h3C, 64'h0010_0010_0055_0013, 4'h0, 8'h3C);
    vt[16] = v(0, 5'd0,  8'h00, 1, 5'd28, 4'h0, 4'h0, 32'h3C, 64'h0010_0010_0055_0013, 4'h0, 8'h3C);
    vt[17] = v(1, 5'd8,  8'h9A, 1, 5'd8,  4'h0, 4'h0, 32'h0,  64'h0010_0010_0055_0013, 4'h0, 8'h00);
    vt[18] = v(0, 5'd0,  8'h00, 1, 5'd8,  4'h0, 4'h0, 32'h0,  64'h0010_0010_0055_0013, 4'h0, 8'h9A);
    vt[19] = v(1, 5'd6,  8'h00, 1, 5'd2,  4'h0, 4'h0, 32'h0,  64'h0000_0010_0055_0013, 4'h0, 8'h55);
    vt[20] = v(0, 5'd0,  8'h00, 0, 5'd0,  4'h0, 4'h8, 32'h0,  64'hFFFF_0010_0055_0013, 4'h8, 8'h00);
    vt[21] = v(1, 5'd31, 8'h77, 1, 5'd7,  4'h0, 4'h0, 32'h0,  64'hFFFF_0010_0055_0013, 4'h0, 8'hFF);
    vt[22] = v(0, 5'd0,  8'h00, 1, 5'd31, 4'h0, 4'h0, 32'h0,  64'hFFFF_0010_0055_0013, 4'h0, 8'h00);

    for (int i = 0; i < 23; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_en = vt[i].re; rd_addr = vt[i].ra;
      ptr_inc = vt[i].inc; ptr_dec = vt[i].dec; sfr_in = vt[i].sin;
      tick();
      chk($sformatf("vec%0d_ptr_out", i), ptr_out, vt[i].eptr);
      chk($sformatf("vec%0d_ptr_wrap", i), {60'd0, ptr_wrap}, {60'd0, vt[i].ewrap});
      chk($sformatf("vec%0d_rd_data", i), {56'd0, rd_data}, {56'd0, vt[i].erd});
    end
    idle();
    chk("vec_sfr_out0", {56'd0, sfr_out[7:0]}, 64'h9A);

`ifdef SFR_WRITE_MASK_EN
    wr_en = 1; wr_addr = 5'd8; wr_data = 8'hFF; wr_mask = 8'h0F;
    tick();
    idle();
    chk("mask_sfr_out0", {56'd0, sfr_out[7:0]}, 64'h9F);
`endif

    // Fill everything nonzero, then reset with requests present.
    for (int a = 0; a < 28; a++) begin
      wr_en = 1; wr_addr = 5'(a); wr_data = 8'hA5; sfr_in = 32'hFFFF_FFFF;
      tick();
    end
    wr_en = 1; wr_addr = 5'd9; wr_data = 8'h11; rd_en = 1; rd_addr = 5'd3;
    ptr_inc = 4'hF; nreset = 0;
    tick();
    chk("midreset_ptr_out", ptr_out, 64'd0);
    chk("midreset_sfr_out", {32'd0, sfr_out}, 64'd0);
    chk("midreset_rd_data", {56'd0, rd_data}, 64'd0);
    chk("midreset_ptr_wrap", {60'd0, ptr_wrap}, 64'd0);
    nreset = 1;
    idle();
    sfr_in = 0;
    tick();
    chk("postreset_ptr_out", ptr_out, 64'd0);

    // Back-to-back increments advance one per cycle.
    ptr_inc = 4'h1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("b2b_inc%0d", c), {48'd0, ptr_out[15:0]}, 64'(c));
    end
    idle();

    for (int c = 0; c < 1500; c++) begin
      nreset  = ($urandom_range(0, 99) != 0);
      wr_en   = $urandom_range(0, 2) == 0;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 8'($urandom);
      wr_mask = 8'($urandom);
      rd_en   = $urandom_range(0, 1) == 1;
      rd_addr = 5'($urandom_range(0, 31));
      ptr_inc = 4'($urandom);
      ptr_dec = 4'($urandom);
      sfr_in  = $urandom;
      // Bias some pointers toward the wrap edges.
      if ($urandom_range(0, 15) == 0) begin
        wr_en = 1; wr_addr = 5'($urandom_range(0, 7));
        wr_data = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        wr_mask = 8'hFF;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
